// File: rtl/hdop_pkg.sv
// Shared encodings for the hdop hypervector datapath and its command sequencer.
// Used by the sequencer, the funct7 decoder and the MAP wrapper.
package hdop_pkg;

    localparam logic [6:0] F7_HOLD      = 7'd0;
    localparam logic [6:0] F7_PERM      = 7'd1;
    localparam logic [6:0] F7_LOAD_CA90 = 7'd2;
    localparam logic [6:0] F7_LOAD_BUND = 7'd3;
    localparam logic [6:0] F7_BIND_CA90 = 7'd4;
    localparam logic [6:0] F7_BIND_BUND = 7'd5;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_BIND = 2'b10,
        OP_PERM = 2'b11
    } op_sel_e;

    typedef enum logic {
        SRC_CA90 = 1'b0,
        SRC_BUND = 1'b1
    } src_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } seq_state_e;

endpackage

// File: rtl/hdop_decode.sv
// Combinational funct7 decoder: maps an operation code onto hdop source/op selects.
// Illegal codes decode to HOLD from the bundler so the datapath is never disturbed.
module hdop_decode
    import hdop_pkg::*;
(
    input  logic [6:0] funct7_i,
    output src_sel_e   src_sel_o,
    output op_sel_e    op_sel_o,
    output logic       legal_o
);

    always_comb begin
        src_sel_o = SRC_BUND;
        op_sel_o  = OP_HOLD;
        legal_o   = 1'b1;
        case (funct7_i)
            F7_HOLD: begin
                src_sel_o = SRC_BUND;
                op_sel_o  = OP_HOLD;
            end
            F7_PERM: begin
                src_sel_o = SRC_BUND;
                op_sel_o  = OP_PERM;
            end
            F7_LOAD_CA90: begin
                src_sel_o = SRC_CA90;
                op_sel_o  = OP_LOAD;
            end
            F7_LOAD_BUND: begin
                src_sel_o = SRC_BUND;
                op_sel_o  = OP_LOAD;
            end
            F7_BIND_CA90: begin
                src_sel_o = SRC_CA90;
                op_sel_o  = OP_BIND;
            end
            F7_BIND_BUND: begin
                src_sel_o = SRC_BUND;
                op_sel_o  = OP_BIND;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hdop_cmd_seq.sv
// Command sequencer for hdop: accepts one command, issues its op N times, waits out the
// datapath latency and returns the result over a valid/ready response channel.
module hdop_cmd_seq
    import hdop_pkg::*;
#(
    parameter int unsigned HDOP_LAT = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_funct7,
    input  logic [63:0]      cmd_rs1,
    input  logic [63:0]      cmd_rs2,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_rd,
    output logic             resp_err,
    output logic             busy,
    output logic [63:0]      hd_rs1,
    output logic [63:0]      hd_rs2,
    output logic             hd_src_sel,
    output logic [1:0]       hd_op_sel,
    input  logic [63:0]      hd_rd
);

    localparam int unsigned LAT_W = $clog2(HDOP_LAT + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    src_sel_e         src_q, src_d;
    op_sel_e          op_q, op_d;
    logic [63:0]      rs1_q, rs1_d;
    logic [63:0]      rs2_q, rs2_d;
    logic [63:0]      resp_rd_q, resp_rd_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    src_sel_e         hd_src_q, hd_src_d;
    op_sel_e          hd_op_q, hd_op_d;

    src_sel_e dec_src;
    op_sel_e  dec_op;
    logic     dec_legal;

    hdop_decode u_decode (
        .funct7_i  (cmd_funct7),
        .src_sel_o (dec_src),
        .op_sel_o  (dec_op),
        .legal_o   (dec_legal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        src_d      = src_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        resp_rd_d  = resp_rd_q;
        resp_err_d = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    rs1_d = cmd_rs1;
                    rs2_d = cmd_rs2;
                    src_d = dec_src;
                    op_d  = dec_op;
                    cnt_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                    if (dec_legal) begin
                        state_d = StIssue;
                    end else begin
                        state_d    = StResp;
                        resp_rd_d  = '0;
                        resp_err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                // cnt_q counts issues still owed, including the current cycle
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StWait;
                    lat_d   = LAT_W'(HDOP_LAT);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWait: begin
                if (lat_q == LAT_W'(1)) begin
                    state_d    = StResp;
                    resp_rd_d  = hd_rd;
                    resp_err_d = 1'b0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Outputs are registered from the next state so they line up with it exactly.
        cmd_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
        busy_d       = (state_d != StIdle);
        hd_op_d      = (state_d == StIssue) ? op_d : OP_HOLD;
        hd_src_d     = (state_d == StIssue) ? src_d : SRC_BUND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            lat_q        <= '0;
            src_q        <= SRC_BUND;
            op_q         <= OP_HOLD;
            rs1_q        <= '0;
            rs2_q        <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            hd_src_q     <= SRC_BUND;
            hd_op_q      <= OP_HOLD;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            src_q        <= src_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            hd_src_q     <= hd_src_d;
            hd_op_q      <= hd_op_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign hd_rs1     = rs1_q;
    assign hd_rs2     = rs2_q;
    assign hd_src_sel = hd_src_q;
    assign hd_op_sel  = hd_op_q;

endmodule
